// File: rtl/simmem_pkg.sv
// Shared types and constants for the simmem write-side requester.
package simmem_pkg;

    localparam int IdW        = 4;
    localparam int AddrW      = 32;
    localparam int BurstLenW  = 4;
    localparam int BurstSizeW = 3;
    localparam int DataW      = 64;

    // AXI-style length field: the burst carries burst_len + 1 beats.
    localparam int MaxBurstLenField = 15;
    localparam int MaxBurstEffLen   = 16;
    // Wide enough to hold MaxBurstEffLen itself.
    localparam int XBurstEffLenW    = $clog2(MaxBurstEffLen) + 1;
    // Beat index inside a burst (0 .. MaxBurstEffLen-1).
    localparam int BeatW            = $clog2(MaxBurstEffLen);
    // Burst sequence tag carried in the data payload.
    localparam int SeqW             = 8;

    typedef struct packed {
        logic [IdW-1:0]        id;
        logic [AddrW-1:0]      addr;
        logic [BurstLenW-1:0]  burst_len;
        logic [BurstSizeW-1:0] burst_size;
    } waddr_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic             last;
    } wdata_t;

    typedef enum logic {
        D_IDLE  = 1'b0,
        D_BURST = 1'b1
    } dstate_e;

    // Number of beats a burst really carries, saturated at MaxBurstEffLen.
    function automatic logic [XBurstEffLenW-1:0] get_effective_burst_len(
        input logic [BurstLenW-1:0] burst_len
    );
        logic [XBurstEffLenW-1:0] eff;
        eff = XBurstEffLenW'(burst_len) + XBurstEffLenW'(1);
        if (eff > XBurstEffLenW'(MaxBurstEffLen)) begin
            eff = XBurstEffLenW'(MaxBurstEffLen);
        end
        return eff;
    endfunction

endpackage

// File: rtl/simmem_requester_fifo.sv
// Small synchronous FIFO with occupancy count; head is read straight from
// the storage registers so a pushed entry is visible the following cycle.
module simmem_requester_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CntW'(Depth));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !w_full;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    // Storage write; contents need no reset because the count guards reads.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; Depth is a power of two so pointers wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/simmem_write_requester.sv
// Write-side requester: queues burst commands, issues write addresses from
// one queue and generates the matching data beats from a second queue, so
// the two channels progress independently.
module simmem_write_requester
    import simmem_pkg::*;
#(
    parameter int QueueDepth     = 4,
    parameter bit AllowDataFirst = 1'b1
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  waddr_t cmd_i,
    input  logic   cmd_valid_i,
    output logic   cmd_ready_o,
    output waddr_t waddr_o,
    output logic   waddr_valid_o,
    input  logic   waddr_ready_i,
    output wdata_t wdata_o,
    output logic   wdata_valid_o,
    input  logic   wdata_ready_i,
    output logic   idle_o
);

    localparam int CntW      = $clog2(QueueDepth) + 1;
    localparam int LenEntryW = XBurstEffLenW + SeqW;

    // Command side
    logic                     w_cmd_hs;
    logic [SeqW-1:0]          r_seq;

    // Address queue
    waddr_t                   w_addr_head;
    logic                     w_addr_empty;
    logic [CntW-1:0]          w_addr_count;
    logic                     w_waddr_hs;

    // Length queue: {effective length, seq}
    logic [LenEntryW-1:0]     w_len_entry;
    logic [LenEntryW-1:0]     w_len_head;
    logic                     w_len_empty;
    logic [CntW-1:0]          w_len_count;
    logic                     w_len_pop;
    logic [XBurstEffLenW-1:0] w_head_len;
    logic [SeqW-1:0]          w_head_seq;

    // Data FSM
    dstate_e                  r_state;
    dstate_e                  w_state_next;
    logic [XBurstEffLenW-1:0] r_len;
    logic [SeqW-1:0]          r_burst_seq;
    logic [BeatW-1:0]         r_beat;
    logic                     w_last;
    logic                     w_beat_hs;
    logic                     w_gate_open;

    // Ready depends only on current occupancy, so a pop in the same cycle
    // cannot make room for a push.
    assign cmd_ready_o = (w_addr_count != CntW'(QueueDepth)) &&
                         (w_len_count  != CntW'(QueueDepth));
    assign w_cmd_hs    = cmd_valid_i && cmd_ready_o;
    assign w_len_entry = {get_effective_burst_len(cmd_i.burst_len), r_seq};

    simmem_requester_fifo #(
        .Width ($bits(waddr_t)),
        .Depth (QueueDepth)
    ) u_addr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_cmd_hs),
        .data_i  (cmd_i),
        .pop_i   (w_waddr_hs),
        .data_o  (w_addr_head),
        .empty_o (w_addr_empty),
        .count_o (w_addr_count)
    );

    simmem_requester_fifo #(
        .Width (LenEntryW),
        .Depth (QueueDepth)
    ) u_len_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_cmd_hs),
        .data_i  (w_len_entry),
        .pop_i   (w_len_pop),
        .data_o  (w_len_head),
        .empty_o (w_len_empty),
        .count_o (w_len_count)
    );

    assign w_head_len = w_len_head[LenEntryW-1:SeqW];
    assign w_head_seq = w_len_head[SeqW-1:0];

    // Address channel: head of the queue, forced to zero while empty.
    assign waddr_valid_o = !w_addr_empty;
    assign waddr_o       = w_addr_empty ? '0 : w_addr_head;
    assign w_waddr_hs    = waddr_valid_o && waddr_ready_i;

    // Sequence tag assigned to each accepted command, wrapping naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seq <= '0;
        end else if (w_cmd_hs) begin
            r_seq <= r_seq + SeqW'(1);
        end
    end

    // Gate on data start: open always, or only once an address is ahead.
    generate
        if (AllowDataFirst) begin : g_data_first
            assign w_gate_open = 1'b1;
        end else begin : g_addr_first
            logic [CntW-1:0] r_addr_ahead;

            // Count addresses issued whose bursts have not yet started.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_addr_ahead <= '0;
                end else begin
                    case ({w_waddr_hs, w_len_pop})
                        2'b10:   r_addr_ahead <= r_addr_ahead + CntW'(1);
                        2'b01:   r_addr_ahead <= r_addr_ahead - CntW'(1);
                        default: r_addr_ahead <= r_addr_ahead;
                    endcase
                end
            end

            assign w_gate_open = (r_addr_ahead != '0);
        end
    endgenerate

    assign w_last = ({1'b0, r_beat} == (r_len - XBurstEffLenW'(1)));

    // Data FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst context: latched on burst entry, beat index advances per handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len       <= '0;
            r_burst_seq <= '0;
            r_beat      <= '0;
        end else if (w_len_pop) begin
            r_len       <= w_head_len;
            r_burst_seq <= w_head_seq;
            r_beat      <= '0;
        end else if (w_beat_hs) begin
            r_beat      <= r_beat + BeatW'(1);
        end
    end

    // Next state, length-queue pop and data channel outputs.
    always_comb begin
        w_state_next  = r_state;
        w_len_pop     = 1'b0;
        w_beat_hs     = 1'b0;
        wdata_valid_o = 1'b0;
        wdata_o       = '0;
        case (r_state)
            D_IDLE: begin
                if (!w_len_empty && w_gate_open) begin
                    w_state_next = D_BURST;
                    w_len_pop    = 1'b1;
                end
            end
            D_BURST: begin
                wdata_valid_o                      = 1'b1;
                wdata_o.data[SeqW+BeatW-1:0]       = {r_burst_seq, r_beat};
                wdata_o.last                       = w_last;
                if (wdata_ready_i) begin
                    w_beat_hs = 1'b1;
                    if (w_last) begin
                        w_state_next = D_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = D_IDLE;
            end
        endcase
    end

    assign idle_o = w_addr_empty && w_len_empty && (r_state == D_IDLE);

endmodule
